// File: rtl/diagonal_collector.sv
// Collects a 4x4 fp32 matrix delivered as seven anti-diagonal wavefront beats.
// Optional macro TRANSPOSE_EN stores element (i,j) at position (j,i) instead.
module diagonal_collector (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [31:0]  d1,
  input  logic [31:0]  d2,
  input  logic [31:0]  d3,
  input  logic [31:0]  d4,
  output logic [511:0] m_flat,
  output logic         busy,
  output logic         done,
  output logic [2:0]   beat
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   beat_q, beat_d;
  logic [511:0] m_q, m_d;
  logic         busy_q, done_q;
  logic         capture_s;
  logic [31:0]  lane_s [4];

  // Returns {lane_active, element_index} for lane l on beat b.
  function automatic logic [4:0] lane_target(input logic [2:0] b, input logic [1:0] l);
    logic [2:0] n;
    logic [1:0] row;
    logic [1:0] col;
    logic       ok;
    if (b <= 3'd3) begin
      n   = b + 3'd1;
      row = l;
      col = b[1:0] - l;
    end else begin
      n   = 3'd7 - b;
      row = b[1:0] + 2'd1 + l;
      col = 2'd3 - l;
    end
    ok = ({1'b0, l} < n);
`ifdef TRANSPOSE_EN
    return {ok, col, row};
`else
    return {ok, row, col};
`endif
  endfunction

  assign lane_s[0] = d1;
  assign lane_s[1] = d2;
  assign lane_s[2] = d3;
  assign lane_s[3] = d4;

  assign capture_s = (state_q == ST_COLLECT) && in_valid;

  // Next-state and beat counter logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          beat_d  = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          if (beat_q == 3'd6) begin
            state_d = ST_DONE;
            beat_d  = 3'd0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
    endcase
  end

  // Matrix write path: only the active lanes of a captured beat touch storage.
  always_comb begin
    logic [4:0] tgt;
    m_d = m_q;
    tgt = 5'd0;
    for (int l = 0; l < 4; l++) begin
      tgt = lane_target(beat_q, 2'(l));
      m_d[{tgt[3:0], 5'd0} +: 32] = (capture_s && tgt[4]) ? lane_s[l]
                                                          : m_d[{tgt[3:0], 5'd0} +: 32];
    end
  end

  // State, counter, matrix and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 3'd0;
      m_q     <= 512'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      m_q     <= m_d;
      busy_q  <= (state_d == ST_COLLECT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign m_flat = m_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign beat   = beat_q;

endmodule

// File: tb/tb_diagonal_collector.sv
// Directed, table-driven bench for diagonal_collector plus gap and mid-op reset sequences.
module tb_diagonal_collector;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [31:0]  d1, d2, d3, d4;
  logic [511:0] m_flat;
  logic         busy;
  logic         done;
  logic [2:0]   beat;

  int checks = 0;
  int errors = 0;

  logic [31:0] lane_tab [7][4];

  typedef struct {
    logic        start;
    logic        vld;
    int          bi;
    logic        e_busy;
    logic        e_done;
    logic [2:0]  e_beat;
    int          epos;
    logic [31:0] eval;
  } vec_t;

  vec_t vecs [12];

  diagonal_collector dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .m_flat(m_flat), .busy(busy), .done(done), .beat(beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Logical element index (4*i+j) to physical storage position.
  function automatic int phys(input int p);
`ifdef TRANSPOSE_EN
    return (p % 4) * 4 + (p / 4);
`else
    return p;
`endif
  endfunction

  function automatic logic [31:0] elem(input int p);
    return m_flat[phys(p)*32 +: 32];
  endfunction

  function automatic logic [31:0] ref_val(input int p);
    return 32'((p / 4 + 1) * 16 + (p % 4 + 1));
  endfunction

  task automatic set_lanes(input int b);
    d1 = lane_tab[b][0];
    d2 = lane_tab[b][1];
    d3 = lane_tab[b][2];
    d4 = lane_tab[b][3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_matrix(input string name);
    for (int p = 0; p < 16; p++) check($sformatf("%s_e%0d", name, p), elem(p), ref_val(p));
  endtask

  initial begin
    int ndone;
    lane_tab[0] = '{32'h11, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    lane_tab[1] = '{32'h12, 32'h21, 32'hDEADBEEF, 32'hDEADBEEF};
    lane_tab[2] = '{32'h13, 32'h22, 32'h31, 32'hDEADBEEF};
    lane_tab[3] = '{32'h14, 32'h23, 32'h32, 32'h41};
    lane_tab[4] = '{32'h24, 32'h33, 32'h42, 32'hDEADBEEF};
    lane_tab[5] = '{32'h34, 32'h43, 32'hDEADBEEF, 32'hDEADBEEF};
    lane_tab[6] = '{32'h44, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

    //           start vld bi busy done beat epos eval
    vecs[0]  = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 3'd0, 9,  32'h0};
    vecs[1]  = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 3'd0, 0,  32'h0};
    vecs[2]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 3'd1, 0,  32'h11};
    vecs[3]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 3'd1, 4,  32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 3'd2, 4,  32'h21};
    vecs[5]  = '{1'b0, 1'b1, 2, 1'b1, 1'b0, 3'd3, 8,  32'h31};
    vecs[6]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 3'd4, 9,  32'h32};
    vecs[7]  = '{1'b0, 1'b1, 4, 1'b1, 1'b0, 3'd5, 7,  32'h24};
    vecs[8]  = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 3'd6, 14, 32'h43};
    vecs[9]  = '{1'b0, 1'b1, 6, 1'b0, 1'b1, 3'd0, 15, 32'h44};
    vecs[10] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 3'd0, 15, 32'h44};
    vecs[11] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 3'd0, 12, 32'h41};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_lanes(0);
    #12;
    check("rst_m_zero", {31'd0, |m_flat}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_beat", {29'd0, beat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Normal collection with illegal-input rows interleaved.
    for (int v = 0; v < 12; v++) begin
      start    = vecs[v].start;
      in_valid = vecs[v].vld;
      set_lanes(vecs[v].bi);
      tick();
      check($sformatf("v%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].e_busy});
      check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].e_done});
      check($sformatf("v%0d_beat", v), {29'd0, beat}, {29'd0, vecs[v].e_beat});
      check($sformatf("v%0d_elem", v), elem(vecs[v].epos), vecs[v].eval);
    end
    check_matrix("normal");
    check("normal_e21", elem(9), 32'h32);
    check("normal_e33", elem(15), 32'h44);

    // Gaps: clear, then three idle cycles before every beat.
    rst = 1'b1; #2;
    check("gap_rst_m", {31'd0, |m_flat}, 32'd0);
    rst = 1'b0; start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b0;
      set_lanes(b);
      for (int g = 0; g < 3; g++) begin
        tick();
        check($sformatf("gap_b%0d_busy", b), {31'd0, busy}, 32'd1);
        check($sformatf("gap_b%0d_beat", b), {29'd0, beat}, 32'(b));
      end
      in_valid = 1'b1;
      tick();
      if (done) ndone++;
    end
    in_valid = 1'b0;
    check("gap_done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("gap_done_clear", {31'd0, done}, 32'd0);
    check_matrix("gap");

    // Mid-op reset after beat 3, then a fresh collection.
    start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; set_lanes(b); tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1; #1;
    check("midrst_m", {31'd0, |m_flat}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_beat", {29'd0, beat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; in_valid = 1'b1; set_lanes(3);
    tick();
    start = 1'b0;
    check("midrst_beat0", {29'd0, beat}, 32'd0);
    ndone = 0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1; set_lanes(b); tick();
      if (done) ndone++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_done_once", 32'(ndone), 32'd1);
    check_matrix("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/diagonal_collector.md
DIAGONAL_COLLECTOR -- requirements
Module: diagonal_collector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begins a 7-beat collection when the block is idle.
REQ-004 SHALL have port in_valid, input, 1 bit: qualifies d1..d4 as one diagonal beat.
REQ-005 SHALL have ports d1, d2, d3, d4, input, 32 bits each: diagonal lanes 0..3 in wavefront order, carrying fp32 bit patterns.
REQ-006 SHALL have port m_flat, output, 512 bits: assembled 4x4 matrix; element (i,j) (0-based) at bits [32*(4*i+j)+31 : 32*(4*i+j)].
REQ-007 SHALL have port busy, output, 1 bit: high while in COLLECT.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the matrix is complete.
REQ-009 SHALL have port beat, output, 3 bits: index of the next beat to be captured.

Function
REQ-010 SHALL implement states IDLE, COLLECT and DONE.
REQ-011 Transition rules SHALL be: IDLE with start=1 -> COLLECT, beat=0; COLLECT with in_valid=1 at beat 6 -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-012 In COLLECT with in_valid=1, beat b (0..6) SHALL write lanes l = 0..n-1, where n = 4-|b-3|; beat SHALL then increment by 1.
REQ-013 For b<=3, lane l SHALL write element (row l, col b-l); for b>=4, lane l SHALL write element (row b-3+l, col 3-l).
REQ-014 Lanes l>=n SHALL be ignored; no element outside the diagonal SHALL change.
REQ-015 Cycles in COLLECT with in_valid=0 SHALL change nothing; gaps of any length between beats are legal.
REQ-016 done SHALL be 1 exactly during the DONE cycle, i.e. the cycle after beat 6 is captured; m_flat SHALL be complete in that cycle.
REQ-017 m_flat SHALL be registered and SHALL hold its value in IDLE and DONE until the next write.
REQ-018 start SHALL be ignored in COLLECT and in DONE.
REQ-019 in_valid SHALL be ignored in IDLE and DONE; in particular, start=1 with in_valid=1 in IDLE SHALL NOT capture that beat.
REQ-020 busy SHALL equal (state==COLLECT); beat SHALL read 0 in IDLE and DONE.
REQ-021 No arithmetic SHALL be performed on the data; values SHALL be stored bit-exact.

Reset
REQ-022 rst=1 SHALL force, asynchronously: state=IDLE, beat=0, busy=0, done=0, m_flat=0.
REQ-023 rst asserted mid-COLLECT SHALL abort the collection; the next start SHALL begin again at beat 0.

Configuration
REQ-024 With macro TRANSPOSE_EN defined, element (i,j) per REQ-013 SHALL instead be written to position (j,i) of m_flat.
REQ-025 Without TRANSPOSE_EN, storage SHALL follow REQ-013 unchanged; the port list SHALL be identical in both builds.

Verification
REQ-026 Normal collection: reset; start; 7 consecutive beats carrying element (i,j)=32'h000000(i+1)(j+1) (beat0 d1=0x11; beat3 d1..d4=0x14,0x23,0x32,0x41) -> done pulses 1 cycle after beat 6; m_flat element(2,1)=0x32, element(3,3)=0x44.
REQ-027 Gaps: same data with in_valid low for 3 cycles between every beat -> identical m_flat; busy high throughout; beat steps only on valid cycles.
REQ-028 Ignored lanes: beat 0 with d2..d4=32'hDEADBEEF -> elements (1,0), (2,0) and (3,0) unchanged until their own beats.
REQ-029 Mid-op reset: rst asserted after beat 3 -> m_flat=0, busy=0; a fresh start plus 7 beats -> correct matrix, done once.
REQ-030 Illegal inputs: start during COLLECT and in_valid in IDLE -> no state or beat change; start with in_valid in the same IDLE cycle -> beat=0 after entering COLLECT.
REQ-031 TRANSPOSE_EN build with the REQ-026 stimulus -> element(1,2)=0x32, element(0,3)=0x41.
